// File: rtl/id_stage_reg.sv
// ID/EXE pipeline register. Captures the decoded bundle and register-file
// operands each rising edge, with freeze (hold), hazard (bubble) and flush (kill).
module id_stage_reg #(
   parameter int ADDRESS_LEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   freeze,
   input  logic                   flush,
   input  logic                   hazard,
   input  logic                   valid_in,
   input  logic [ADDRESS_LEN-1:0] pc_in,
   input  logic [ADDRESS_LEN-1:0] val_rn_in,
   input  logic [ADDRESS_LEN-1:0] val_rm_in,
   input  logic [3:0]             src1_in,
   input  logic [3:0]             src2_in,
   input  logic [3:0]             dest_in,
   input  logic [3:0]             exe_cmd_in,
   input  logic                   mem_r_en_in,
   input  logic                   mem_w_en_in,
   input  logic                   wb_en_in,
   input  logic                   b_in,
   input  logic                   s_in,
   input  logic                   imm_in,
   input  logic [11:0]            shift_operand_in,
   input  logic [23:0]            signed_imm_24_in,
   input  logic [3:0]             status_in,
   output logic                   valid,
   output logic [ADDRESS_LEN-1:0] pc,
   output logic [ADDRESS_LEN-1:0] val_rn,
   output logic [ADDRESS_LEN-1:0] val_rm,
   output logic [3:0]             src1,
   output logic [3:0]             src2,
   output logic [3:0]             dest,
   output logic [3:0]             exe_cmd,
   output logic                   mem_r_en,
   output logic                   mem_w_en,
   output logic                   wb_en,
   output logic                   b,
   output logic                   s,
   output logic                   imm,
   output logic [11:0]            shift_operand,
   output logic [23:0]            signed_imm_24,
   output logic [3:0]             status
);

   typedef struct packed {
      logic                   valid;
      logic                   memREn;
      logic                   memWEn;
      logic                   wbEn;
      logic                   b;
      logic                   s;
      logic [ADDRESS_LEN-1:0] pc;
      logic [ADDRESS_LEN-1:0] valRn;
      logic [ADDRESS_LEN-1:0] valRm;
      logic [3:0]             src1;
      logic [3:0]             src2;
      logic [3:0]             dest;
      logic [3:0]             exeCmd;
      logic                   imm;
      logic [11:0]            shiftOperand;
      logic [23:0]            signedImm24;
      logic [3:0]             status;
   } bundle_t;

   bundle_t bundleQ;
   bundle_t bundleD;
   bundle_t bundleIn;

   always_comb begin
      bundleIn.valid        = valid_in;
      bundleIn.memREn       = mem_r_en_in;
      bundleIn.memWEn       = mem_w_en_in;
      bundleIn.wbEn         = wb_en_in;
      bundleIn.b            = b_in;
      bundleIn.s            = s_in;
      bundleIn.pc           = pc_in;
      bundleIn.valRn        = val_rn_in;
      bundleIn.valRm        = val_rm_in;
      bundleIn.src1         = src1_in;
      bundleIn.src2         = src2_in;
      bundleIn.dest         = dest_in;
      bundleIn.exeCmd       = exe_cmd_in;
      bundleIn.imm          = imm_in;
      bundleIn.shiftOperand = shift_operand_in;
      bundleIn.signedImm24  = signed_imm_24_in;
      bundleIn.status       = status_in;
   end

   // Flush beats freeze beats hazard; a bubble or an invalid slot still loads
   // data fields (so forwarding sees fresh indices) but never any control bit.
   always_comb begin
      bundleD = bundleQ;
      if (flush) begin
         bundleD = '0;
      end else if (!freeze) begin
         bundleD = bundleIn;
         if (hazard || !valid_in) begin
            bundleD.valid  = 1'b0;
            bundleD.memREn = 1'b0;
            bundleD.memWEn = 1'b0;
            bundleD.wbEn   = 1'b0;
            bundleD.b      = 1'b0;
            bundleD.s      = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bundleQ <= '0;
      end else begin
         bundleQ <= bundleD;
      end
   end

   assign valid         = bundleQ.valid;
   assign mem_r_en      = bundleQ.memREn;
   assign mem_w_en      = bundleQ.memWEn;
   assign wb_en         = bundleQ.wbEn;
   assign b             = bundleQ.b;
   assign s             = bundleQ.s;
   assign pc            = bundleQ.pc;
   assign val_rn        = bundleQ.valRn;
   assign val_rm        = bundleQ.valRm;
   assign src1          = bundleQ.src1;
   assign src2          = bundleQ.src2;
   assign dest          = bundleQ.dest;
   assign exe_cmd       = bundleQ.exeCmd;
   assign imm           = bundleQ.imm;
   assign shift_operand = bundleQ.shiftOperand;
   assign signed_imm_24 = bundleQ.signedImm24;
   assign status        = bundleQ.status;

endmodule

// File: tb/tb_id_stage_reg.sv
// Scoreboard bench for id_stage_reg: directed vectors push hand-derived
// expected bundles; a monitor pops and compares after every rising edge.
module tb_id_stage_reg;

   typedef struct packed {
      logic        valid;
      logic        memREn;
      logic        memWEn;
      logic        wbEn;
      logic        b;
      logic        s;
      logic [31:0] pc;
      logic [31:0] valRn;
      logic [31:0] valRm;
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic [3:0]  dest;
      logic [3:0]  exeCmd;
      logic        imm;
      logic [11:0] shiftOperand;
      logic [23:0] signedImm24;
      logic [3:0]  status;
   } bundle_t;

   logic    clk = 1'b0;
   logic    rst, freeze, flush, hazard;
   bundle_t inB;
   bundle_t outB;

   bundle_t expQ[$];
   string   nameQ[$];
   int      checks = 0;
   int      passed = 0;
   bit      stimDone = 1'b0;

   always #5 clk = ~clk;

   id_stage_reg #(.ADDRESS_LEN(32)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard(hazard),
      .valid_in(inB.valid), .pc_in(inB.pc), .val_rn_in(inB.valRn), .val_rm_in(inB.valRm),
      .src1_in(inB.src1), .src2_in(inB.src2), .dest_in(inB.dest), .exe_cmd_in(inB.exeCmd),
      .mem_r_en_in(inB.memREn), .mem_w_en_in(inB.memWEn), .wb_en_in(inB.wbEn),
      .b_in(inB.b), .s_in(inB.s), .imm_in(inB.imm),
      .shift_operand_in(inB.shiftOperand), .signed_imm_24_in(inB.signedImm24),
      .status_in(inB.status),
      .valid(outB.valid), .pc(outB.pc), .val_rn(outB.valRn), .val_rm(outB.valRm),
      .src1(outB.src1), .src2(outB.src2), .dest(outB.dest), .exe_cmd(outB.exeCmd),
      .mem_r_en(outB.memREn), .mem_w_en(outB.memWEn), .wb_en(outB.wbEn),
      .b(outB.b), .s(outB.s), .imm(outB.imm),
      .shift_operand(outB.shiftOperand), .signed_imm_24(outB.signedImm24),
      .status(outB.status)
   );

   function automatic bundle_t clearCtl(input bundle_t x);
      bundle_t r = x;
      r.valid = 1'b0; r.memREn = 1'b0; r.memWEn = 1'b0;
      r.wbEn  = 1'b0; r.b      = 1'b0; r.s      = 1'b0;
      return r;
   endfunction

   // Drive one edge's worth of inputs on the falling edge and queue what the
   // outputs must show after the following rising edge.
   task automatic applyStimulus(input bundle_t stim, input logic r, input logic fr,
                                input logic fl, input logic hz, input bundle_t expB,
                                input string name);
      @(negedge clk);
      inB    = stim;
      rst    = r;
      freeze = fr;
      flush  = fl;
      hazard = hz;
      expQ.push_back(expB);
      nameQ.push_back(name);
   endtask

   task automatic checkOutput(input string name, input bundle_t expB);
      checks++;
      if (outB === expB) passed++;
      else $display("[TB] FAIL %s: got %h expected %h", name, outB, expB);
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) checkOutput(nameQ.pop_front(), expQ.pop_front());
      end
   end

   initial begin : stimulus
      bundle_t s0, hold;
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; hazard = 1'b0;
      inB = '0;

      s0 = '0;
      s0.valid = 1'b1; s0.wbEn = 1'b1; s0.b = 1'b1; s0.pc = 32'h0000_00AA;
      applyStimulus(s0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "reset");

      s0 = '0;
      s0.valid = 1'b1; s0.wbEn = 1'b1; s0.exeCmd = 4'b0100;
      s0.pc = 32'h10; s0.valRn = 32'd5; s0.valRm = 32'hFFFF_FFFD;
      s0.src1 = 4'd1; s0.src2 = 4'd2; s0.dest = 4'd3; s0.imm = 1'b1;
      s0.shiftOperand = 12'h123; s0.signedImm24 = 24'hFF_FFF0; s0.status = 4'hA;
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b0, s0, "normal_load");
      hold = s0;

      s0.pc = 32'h20; s0.valRn = 32'd9; s0.exeCmd = 4'b0010;
      applyStimulus(s0, 1'b0, 1'b1, 1'b0, 1'b0, hold, "freeze_1");
      applyStimulus(s0, 1'b0, 1'b1, 1'b0, 1'b1, hold, "freeze_2_over_hazard");
      applyStimulus(s0, 1'b0, 1'b1, 1'b0, 1'b0, hold, "freeze_3");
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b0, s0, "freeze_release");

      s0.memREn = 1'b1; s0.wbEn = 1'b1; s0.src1 = 4'd2; s0.valRn = 32'h1234;
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b1, clearCtl(s0), "hazard_bubble_1");
      s0.src1 = 4'd7; s0.valRn = 32'h5678; s0.s = 1'b1;
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b1, clearCtl(s0), "hazard_bubble_2");

      s0.b = 1'b1;
      applyStimulus(s0, 1'b0, 1'b1, 1'b1, 1'b0, '0, "flush_with_freeze");

      s0.memREn = 1'b0; s0.memWEn = 1'b1; s0.pc = 32'h44;
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b0, s0, "load_all_ctl");
      applyStimulus(s0, 1'b0, 1'b0, 1'b1, 1'b1, '0, "flush_with_hazard");

      s0.valid = 1'b0; s0.wbEn = 1'b1; s0.memWEn = 1'b1; s0.pc = 32'h48;
      s0.valRm = 32'hDEAD_BEEF;
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b0, clearCtl(s0), "invalid_slot");

      s0 = '0;
      s0.valid = 1'b1; s0.wbEn = 1'b1; s0.src1 = 4'd6; s0.valRn = 32'd77;
      s0.pc = 32'h4C; s0.exeCmd = 4'b1001; s0.status = 4'h5;
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b0, s0, "wb_same_cycle_r6");

      s0.pc = 32'h50; s0.dest = 4'hF;
      applyStimulus(s0, 1'b1, 1'b0, 1'b0, 1'b0, '0, "reset_mid_stream");
      applyStimulus(s0, 1'b0, 1'b0, 1'b0, 1'b0, s0, "load_after_reset");

      repeat (3) @(negedge clk);
      checks++;
      if (expQ.size() == 0) passed++;
      else $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
      stimDone = 1'b1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
